// File: rtl/taxi_meter.sv
// ---------------------------------------------------------------------------
// taxi_meter
//
// Purpose:
//   Taxi fare meter. A clock divider turns the system clock into 10 ms ticks.
//   Each tick in RUN adds distance, which is billed per UNIT_M metres beyond
//   the included base distance. Each tick in WAIT advances the waiting-time
//   counters, which are billed per WAIT_UNIT seconds. The money, distance and
//   waiting-time registers are frozen while paused or after the trip ends.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   start     in   begin a trip (from IDLE or HOLD)
//   stop      in   end the trip
//   pause     in   freeze all counting
//   waiting   in   vehicle stationary, bill time instead of distance
//   night     in   night surcharge enable
//   speed     in   00/01/10/11 = 1/2/4/6 metres per tick
//   distance  out  trip metres (saturating)
//   wait_sec  out  trip waiting seconds (saturating)
//   money     out  current fare in 0.01 yuan (saturating)
//   state     out  IDLE=0 RUN=1 WAIT=2 PAUSE=3 HOLD=4
//   done      out  one-cycle pulse after the trip enters HOLD
// ---------------------------------------------------------------------------
module taxi_meter #(
    parameter int TICK_DIV  = 200000,
    parameter int DIST_W    = 32,
    parameter int MONEY_W   = 32,
    parameter int BASE_FARE = 600,
    parameter int BASE_DIST = 3000,
    parameter int UNIT_M    = 100,
    parameter int RATE_DAY  = 12,
    parameter int RATE_LONG = 18,
    parameter int LONG_FARE = 2000,
    parameter int NIGHT_ADD = 3,
    parameter int SEC_TICKS = 100,
    parameter int WAIT_UNIT = 60,
    parameter int WAIT_FEE  = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               waiting,
    input  logic               night,
    input  logic [1:0]         speed,
    output logic [DIST_W-1:0]  distance,
    output logic [15:0]        wait_sec,
    output logic [MONEY_W-1:0] money,
    output logic [2:0]         state,
    output logic               done
);

    localparam int DIV_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int SUB_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
    localparam int WU_W  = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
    // acc stays below UNIT_M between ticks and gains at most 6 per tick,
    // so it never reaches 2*UNIT_M when UNIT_M >= 6.
    localparam int ACC_W = $clog2(2 * UNIT_M) + 1;
    localparam int DW1   = DIST_W + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(SEC_TICKS - 1);
    localparam logic [WU_W-1:0]    WU_LAST  = WU_W'(WAIT_UNIT - 1);
    localparam logic [ACC_W-1:0]   UNIT_A   = ACC_W'(UNIT_M);
    localparam logic [DW1-1:0]     BASE_D   = DW1'(BASE_DIST);
    localparam logic [MONEY_W-1:0] BASE_M   = MONEY_W'(BASE_FARE);
    localparam logic [MONEY_W-1:0] LONG_M   = MONEY_W'(LONG_FARE);
    localparam logic [MONEY_W-1:0] RD_M     = MONEY_W'(RATE_DAY);
    localparam logic [MONEY_W-1:0] RL_M     = MONEY_W'(RATE_LONG);
    localparam logic [MONEY_W-1:0] NA_M     = MONEY_W'(NIGHT_ADD);
    localparam logic [MONEY_W-1:0] WF_M     = MONEY_W'(WAIT_FEE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WAIT  = 3'd2,
        PAUSE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   trip_start;
    logic   enter_hold;

    logic [DIV_W-1:0] div;
    logic [SUB_W-1:0] sub;
    logic [WU_W-1:0]  wu;
    logic [ACC_W-1:0] acc;

    logic               counting;
    logic               tick;
    logic [2:0]         step;
    logic [DIST_W-1:0]  dist_new;
    logic [DW1-1:0]     over;
    logic [2:0]         excess;
    logic [ACC_W-1:0]   acc_sum;
    logic               charge;
    logic [ACC_W-1:0]   acc_new;
    logic [MONEY_W-1:0] rate;
    logic [MONEY_W-1:0] money_run;
    logic               sec_wrap;
    logic               unit_wrap;
    logic [MONEY_W-1:0] money_wait;

    // One-bit-wider sum exposes the carry used for saturation.
    function automatic logic [MONEY_W-1:0] sat_money(input logic [MONEY_W-1:0] a,
                                                     input logic [MONEY_W-1:0] b);
        logic [MONEY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[MONEY_W] ? {MONEY_W{1'b1}} : sum[MONEY_W-1:0];
    endfunction

    function automatic logic [DIST_W-1:0] sat_dist(input logic [DIST_W-1:0] a,
                                                   input logic [2:0]        b);
        logic [DW1-1:0] sum;
        sum = {1'b0, a} + DW1'(b);
        return sum[DIST_W] ? {DIST_W{1'b1}} : sum[DIST_W-1:0];
    endfunction

    assign state = cur_state;

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        trip_start = 1'b0;
        case (cur_state)
            IDLE, HOLD: begin
                // start outranks stop here; stop alone is a no-op in HOLD
                if (start) begin
                    trip_start = 1'b1;
                    nxt_state  = waiting ? WAIT : RUN;
                end
            end
            RUN, WAIT: begin
                if (stop)         nxt_state = HOLD;
                else if (pause)   nxt_state = PAUSE;
                else if (waiting) nxt_state = WAIT;
                else              nxt_state = RUN;
            end
            PAUSE: begin
                if (stop)        nxt_state = HOLD;
                else if (!pause) nxt_state = waiting ? WAIT : RUN;
            end
            default: nxt_state = IDLE;
        endcase
        enter_hold = (nxt_state == HOLD) && (cur_state != HOLD);
    end

    // ---- per-tick arithmetic ----
    always_comb begin
        counting = (cur_state == RUN) || (cur_state == WAIT);
        tick     = counting && (div == DIV_LAST);

        case (speed)
            2'b00:   step = 3'd1;
            2'b01:   step = 3'd2;
            2'b10:   step = 3'd4;
            default: step = 3'd6;
        endcase

        dist_new = sat_dist(distance, step);
        over     = {1'b0, dist_new} - BASE_D;
        excess   = 3'd0;
        // only the part of this step lying beyond the base distance is billable
        if ({1'b0, dist_new} > BASE_D) begin
            excess = (over > DW1'(step)) ? step : over[2:0];
        end
        acc_sum = acc + ACC_W'(excess);
        charge  = (acc_sum >= UNIT_A);
        acc_new = charge ? (acc_sum - UNIT_A) : acc_sum;

        // rate is chosen from the fare before this tick's charge
        rate      = ((money >= LONG_M) ? RL_M : RD_M) + (night ? NA_M : '0);
        money_run = charge ? sat_money(money, rate) : money;

        sec_wrap   = (sub == SUB_LAST);
        unit_wrap  = sec_wrap && (wu == WU_LAST);
        money_wait = unit_wrap ? sat_money(money, WF_M) : money;
    end

    // ---- registered counters and outputs ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            div      <= '0;
            sub      <= '0;
            wu       <= '0;
            acc      <= '0;
            distance <= '0;
            wait_sec <= '0;
            money    <= '0;
            done     <= 1'b0;
        end else begin
            done <= enter_hold;
            if (trip_start) begin
                div      <= '0;
                sub      <= '0;
                wu       <= '0;
                acc      <= '0;
                distance <= '0;
                wait_sec <= '0;
                money    <= BASE_M;
            end else if (counting) begin
                div <= tick ? '0 : div + 1'b1;
                if (tick && (cur_state == RUN)) begin
                    distance <= dist_new;
                    acc      <= acc_new;
                    money    <= money_run;
                end
                if (tick && (cur_state == WAIT)) begin
                    sub   <= sec_wrap ? '0 : sub + 1'b1;
                    money <= money_wait;
                    if (sec_wrap) begin
                        wu <= (wu == WU_LAST) ? '0 : wu + 1'b1;
                        if (wait_sec != 16'hFFFF) begin
                            wait_sec <= wait_sec + 16'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_taxi_meter.sv
// ---------------------------------------------------------------------------
// tb_taxi_meter
//
// Directed bench for taxi_meter with a short divider (TICK_DIV=4). A second
// instance with a 6-bit distance shares all inputs to exercise saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_taxi_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic        waiting;
    logic        night;
    logic [1:0]  speed;
    logic [31:0] distance;
    logic [15:0] wait_sec;
    logic [31:0] money;
    logic [2:0]  state;
    logic        done;

    logic [5:0]  distance6;
    logic [15:0] wait_sec6;
    logic [31:0] money6;
    logic [2:0]  state6;
    logic        done6;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    taxi_meter #(
        .TICK_DIV (4),
        .DIST_W   (32),
        .BASE_DIST(10),
        .UNIT_M   (10),
        .LONG_FARE(650),
        .SEC_TICKS(2),
        .WAIT_UNIT(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .waiting (waiting),
        .night   (night),
        .speed   (speed),
        .distance(distance),
        .wait_sec(wait_sec),
        .money   (money),
        .state   (state),
        .done    (done)
    );

    taxi_meter #(
        .TICK_DIV (4),
        .DIST_W   (6),
        .BASE_DIST(10),
        .UNIT_M   (10),
        .LONG_FARE(650),
        .SEC_TICKS(2),
        .WAIT_UNIT(1)
    ) dut6 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .waiting (waiting),
        .night   (night),
        .speed   (speed),
        .distance(distance6),
        .wait_sec(wait_sec6),
        .money   (money6),
        .state   (state6),
        .done    (done6)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        waiting = 1'b0; night = 1'b0; speed = 2'b11;

        // reset held for three edges
        cyc(3);
        check_eq("rst_state", state, 0);
        check_eq("rst_dist", distance, 0);
        check_eq("rst_money", money, 0);
        check_eq("rst_wait", wait_sec, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b1;
        cyc(1);
        check_eq("idle_state", state, 0);

        // base fare and day rate, 6 m per tick
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("start_state", state, 1);
        check_eq("start_money", money, 600);
        check_eq("start_dist", distance, 0);
        cyc(16);
        check_eq("t4_money", money, 612);
        check_eq("t4_dist", distance, 24);
        cyc(4);
        check_eq("t5_money", money, 624);
        check_eq("t5_dist", distance, 30);

        // long-haul crossover
        cyc(16);
        check_eq("t9_money", money, 648);
        check_eq("t9_dist", distance, 54);
        cyc(4);
        check_eq("t10_money", money, 660);
        cyc(8);
        check_eq("t12_money", money, 678);
        check_eq("t12_dist", distance, 72);
        check_eq("sat6_dist", distance6, 63);

        // pause for 10 edges starting with divider at 2
        cyc(2);
        pause = 1'b1;
        cyc(10);
        check_eq("pause_state", state, 3);
        check_eq("pause_dist", distance, 72);
        pause = 1'b0;
        cyc(1);
        check_eq("resume_state", state, 1);
        check_eq("resume_dist", distance, 72);
        cyc(1);
        check_eq("t13_dist", distance, 78);
        check_eq("t13_money", money, 678);

        // stop and pause together end the trip
        stop = 1'b1; pause = 1'b1;
        cyc(1);
        stop = 1'b0; pause = 1'b0;
        check_eq("hold_state", state, 4);
        check_eq("hold_done", done, 1);
        check_eq("hold_dist", distance, 78);
        cyc(1);
        check_eq("hold_done_low", done, 0);
        stop = 1'b1;
        cyc(4);
        stop = 1'b0;
        check_eq("hold_frozen_dist", distance, 78);
        check_eq("hold_frozen_money", money, 678);
        check_eq("hold_stop_ign", state, 4);

        // start wins over stop in HOLD
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check_eq("restart_state", state, 1);
        check_eq("restart_money", money, 600);
        check_eq("restart_dist", distance, 0);
        check_eq("restart_done", done, 0);
        cyc(4);
        check_eq("restart_t1_dist", distance, 6);

        // reset mid-trip
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check_eq("midrst_state", state, 0);
        check_eq("midrst_dist", distance, 0);
        check_eq("midrst_money", money, 0);

        // night surcharge
        night = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(16);
        check_eq("night_t4_money", money, 615);
        cyc(4);
        check_eq("night_t5_money", money, 630);
        check_eq("night_t5_dist", distance, 30);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("night_hold", state, 4);

        // waiting from trip start
        night = 1'b0;
        waiting = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("wait_state", state, 2);
        check_eq("wait_money0", money, 600);
        cyc(8);
        check_eq("wait_sec1", wait_sec, 1);
        check_eq("wait_money1", money, 650);
        cyc(16);
        check_eq("wait_sec3", wait_sec, 3);
        check_eq("wait_money3", money, 750);
        check_eq("wait_dist", distance, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
